// File: rtl/multi_issue_select_if.sv
// -----------------------------------------------------------------------------
// multi_issue_select_if
//   Issue-side handshake bundle between the select block and the dispatch
//   ports: per-port valid/index/ready, the freed-slot mask and the fire count.
//
//   Signals
//     issue_valid  ISSUE_W          port p holds a granted slot
//     issue_idx    ISSUE_W*IDX_W    granted slot of port p at [p*IDX_W +: IDX_W]
//     issue_ready  ISSUE_W          execution unit on port p accepts this cycle
//     issue_fire   DEPTH            OR of one-hot slots accepted this cycle
//     issue_count  CNT_W            number of ports firing this cycle
//
//   Modports
//     master : the select block (drives valid/idx/fire/count, reads ready)
//     slave  : the dispatch side (reads valid/idx/fire/count, drives ready)
// -----------------------------------------------------------------------------
interface multi_issue_select_if #(
    parameter int DEPTH   = 8,
    parameter int IDX_W   = 3,
    parameter int ISSUE_W = 2
);
    localparam int CNT_W = $clog2(ISSUE_W + 1);

    logic [ISSUE_W-1:0]       issue_valid;
    logic [ISSUE_W*IDX_W-1:0] issue_idx;
    logic [ISSUE_W-1:0]       issue_ready;
    logic [DEPTH-1:0]         issue_fire;
    logic [CNT_W-1:0]         issue_count;

    modport master (
        output issue_valid,
        output issue_idx,
        output issue_fire,
        output issue_count,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_idx,
        input  issue_fire,
        input  issue_count,
        output issue_ready
    );
endinterface

// File: rtl/multi_issue_select.sv
// -----------------------------------------------------------------------------
// multi_issue_select
//   Picks up to ISSUE_W ready entries per cycle from a DEPTH-slot issue queue
//   and presents them on registered dispatch ports with a valid/ready
//   handshake. Free ports are filled in ascending port order, each taking the
//   best remaining candidate, so a slot can never sit on two ports at once.
//
//   Build option
//     MULTI_ISSUE_AGE_ORDER_EN defined   : oldest-first selection through a
//                                          DEPTH x DEPTH age matrix.
//     MULTI_ISSUE_AGE_ORDER_EN undefined : lowest-index-first selection, no
//                                          age state; alloc only masks.
//
//   Ports
//     clk            in   clock, rising edge
//     rst_n          in   asynchronous active-low reset
//     alloc_valid_i  in   a slot is being filled this cycle
//     alloc_idx_i    in   slot being filled
//     req_i          in   DEPTH, slot occupied and all sources ready
//     flush_i        in   squash: drop every grant, grant nothing this cycle
//     iss_if         master modport of multi_issue_select_if
//                    (issue_valid/idx/fire/count out, issue_ready in)
// -----------------------------------------------------------------------------
module multi_issue_select #(
    parameter int DEPTH   = 8,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int ISSUE_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_valid_i,
    input  logic [IDX_W-1:0]     alloc_idx_i,
    input  logic [DEPTH-1:0]     req_i,
    input  logic                 flush_i,
    multi_issue_select_if.master iss_if
);
    localparam int CNT_W = $clog2(ISSUE_W + 1);

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Port registers.
    logic [ISSUE_W-1:0] valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q [ISSUE_W];
    logic [IDX_W-1:0]   idx_d [ISSUE_W];

    logic [ISSUE_W-1:0] fire;       // port accepted this cycle
    logic [ISSUE_W-1:0] hold_port;  // valid but stalled: keeps its slot
    logic [DEPTH-1:0]   on_port;    // slot sits in any valid port
    logic [DEPTH-1:0]   held_slots; // slot sits in a stalled port
    logic [DEPTH-1:0]   fire_slots;
    logic [DEPTH-1:0]   alloc_mask;
    logic [DEPTH-1:0]   cand;
    logic [CNT_W-1:0]   fire_cnt;

    assign fire      = valid_q & iss_if.issue_ready;
    assign hold_port = valid_q & ~iss_if.issue_ready;

    // -------------------------------------------------------------------------
    // Slot bookkeeping derived from the port registers.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the block can leave a value unassigned and infer a latch.
        on_port    = '0;
        held_slots = '0;
        fire_slots = '0;
        fire_cnt   = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (valid_q[p]) begin
                on_port[idx_q[p]] = 1'b1;
            end
            if (hold_port[p]) begin
                held_slots[idx_q[p]] = 1'b1;
            end
            if (fire[p]) begin
                fire_slots[idx_q[p]] = 1'b1;
                fire_cnt             = fire_cnt + CNT_W'(1);
            end
        end
    end

    assign alloc_mask = alloc_valid_i ? (DEPTH'(1) << alloc_idx_i) : '0;

    // A slot already on a port is excluded whether it is stalled or firing:
    // a firing slot's req only drops in the following cycle.
    assign cand = req_i & ~on_port & ~alloc_mask;

`ifdef MULTI_ISSUE_AGE_ORDER_EN
    // -------------------------------------------------------------------------
    // Age matrix: age_q[i][j] = 1 means slot i is older than slot j.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;

    // Allocating k makes k the youngest slot: every other slot becomes older
    // than k and k older than nobody. Rows of freed or flushed slots are left
    // stale; they are rewritten when the slot is reallocated.
    always_comb begin
        age_d = age_q;
        if (alloc_valid_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j != int'(alloc_idx_i)) begin
                    age_d[j][alloc_idx_i] = 1'b1;
                    age_d[alloc_idx_i][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the age matrix is real state that steers selection, so it is
        // reset explicitly rather than left as an unreset storage array.
        if (!rst_n) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Oldest candidate: no other candidate is marked older than it. Ties can
    // only arise between never-allocated slots and resolve to the lowest index.
    function automatic pick_t pick_best(input logic [DEPTH-1:0]            c,
                                        input logic [DEPTH-1:0][DEPTH-1:0] age);
        pick_t r;
        logic  older;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            older = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (c[j] && age[j][i]) begin
                    older = 1'b1;
                end
            end
            if (!r.found && c[i] && !older) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction
`else
    // Bottom-up priority: the lowest-numbered candidate wins.
    function automatic pick_t pick_best(input logic [DEPTH-1:0] c);
        pick_t r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r.found && c[i]) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Next-state of the ports: flush > hold > load next selection.
    // -------------------------------------------------------------------------
    always_comb begin : sel_comb
        logic [DEPTH-1:0] remaining;
        pick_t            pk;
        remaining = cand;
        pk        = '0;
        valid_d   = valid_q;
        idx_d     = idx_q;
        for (int p = 0; p < ISSUE_W; p++) begin
            if (flush_i) begin
                valid_d[p] = 1'b0;
            end else if (!hold_port[p]) begin
`ifdef MULTI_ISSUE_AGE_ORDER_EN
                pk = pick_best(remaining, age_q);
`else
                pk = pick_best(remaining);
`endif
                valid_d[p] = pk.found;
                // With no candidate the index is left as is (don't-care).
                if (pk.found) begin
                    idx_d[p]            = pk.idx;
                    remaining[pk.idx]   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            valid_q <= '0;
            for (int p = 0; p < ISSUE_W; p++) begin
                idx_q[p] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        iss_if.issue_idx = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            iss_if.issue_idx[p*IDX_W +: IDX_W] = idx_q[p];
        end
    end

    assign iss_if.issue_valid = valid_q;
    assign iss_if.issue_fire  = fire_slots;
    assign iss_if.issue_count = fire_cnt;

    // Reallocating a slot still parked on a stalled port would corrupt the
    // entry that port is about to dispatch.
    a_alloc_not_held : assert property (
        @(posedge clk) disable iff (!rst_n)
        alloc_valid_i |-> !held_slots[alloc_idx_i]
    );

endmodule
